param_bank_axil: RTL

//  Parametrised AXI4-Lite parameter bank for the HIL model: NUM_PARAMS double-buffered 32-bit

---
 rtl/param_bank_pkg.sv | 24 ++
 rtl/param_bank_axil_if.sv | 103 ++++++++++
 rtl/param_bank_axil.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/param_bank_pkg.sv
// Shared register map, control bit positions and AXI response codes for the
// double-buffered parameter bank.
package param_bank_pkg;

    localparam int REG_CTRL    = 0;
    localparam int REG_STATUS  = 1;
    localparam int REG_NUM     = 2;
    localparam int REG_RSVD    = 3;
    localparam int SHADOW_BASE = 4;

    localparam int CTRL_COMMIT_BIT = 0;
    localparam int CTRL_ABORT_BIT  = 1;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10
    } axi_resp_e;

    // Number of word registers decoded for a given channel count.
    function automatic int reg_count(input int num_params);
        return SHADOW_BASE + 2 * num_params;
    endfunction

endpackage

// File: rtl/param_bank_axil_if.sv
// AXI4-Lite slave handshake for the parameter bank: one outstanding write and
// one outstanding read, exposing simple word-indexed register access strobes.
module param_bank_axil_if
    import param_bank_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_REGS   = 36
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] awaddr,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [31:0]           wdata,
    input  logic [3:0]            wstrb,
    input  logic                  wvalid,
    output logic                  wready,
    output logic [1:0]            bresp,
    output logic                  bvalid,
    input  logic                  bready,
    input  logic [ADDR_WIDTH-1:0] araddr,
    input  logic                  arvalid,
    output logic                  arready,
    output logic [31:0]           rdata,
    output logic [1:0]            rresp,
    output logic                  rvalid,
    input  logic                  rready,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-3:0] wr_idx,
    output logic [31:0]           wr_data,
    output logic [3:0]            wr_strb,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-3:0] rd_idx,
    input  logic [31:0]           rd_data,
    input  logic                  rd_err
);

    logic ready_en;
    logic aw_done;
    logic w_done;
    logic wr_err;
    logic unused_addr_bits;

    // Ready lines stay low until the first clock after reset has been released.
    assign awready = ready_en & ~aw_done & ~bvalid;
    assign wready  = ready_en & ~w_done & ~bvalid;
    assign arready = ready_en & ~rvalid;

    assign wr_en  = aw_done & w_done;
    assign wr_err = 32'(wr_idx) >= NUM_REGS;
    assign rd_en  = arvalid & arready;
    assign rd_idx = araddr[ADDR_WIDTH-1:2];

    assign unused_addr_bits = ^{awaddr[1:0], araddr[1:0]};

    // AW and W are captured independently; the register write fires once both are held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_en <= 1'b0;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
            wr_idx   <= '0;
            wr_data  <= '0;
            wr_strb  <= '0;
            bvalid   <= 1'b0;
            bresp    <= RESP_OKAY;
        end else begin
            ready_en <= 1'b1;
            if (awvalid && awready) begin
                aw_done <= 1'b1;
                wr_idx  <= awaddr[ADDR_WIDTH-1:2];
            end
            if (wvalid && wready) begin
                w_done  <= 1'b1;
                wr_data <= wdata;
                wr_strb <= wstrb;
            end
            if (wr_en) begin
                aw_done <= 1'b0;
                w_done  <= 1'b0;
                bvalid  <= 1'b1;
                bresp   <= wr_err ? RESP_SLVERR : RESP_OKAY;
            end else if (bvalid && bready) begin
                bvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvalid <= 1'b0;
            rdata  <= '0;
            rresp  <= RESP_OKAY;
        end else if (rd_en) begin
            rvalid <= 1'b1;
            rdata  <= rd_data;
            rresp  <= rd_err ? RESP_SLVERR : RESP_OKAY;
        end else if (rvalid && rready) begin
            rvalid <= 1'b0;
        end
    end

endmodule

// File: rtl/param_bank_axil.sv
// Double-buffered AXI4-Lite parameter bank: software fills shadow registers and a
// commit moves the whole set to the active outputs in a single cycle.
module param_bank_axil
    import param_bank_pkg::*;
#(
    parameter int          C_S_AXI_DATA_WIDTH = 32,
    parameter int          C_S_AXI_ADDR_WIDTH = 8,
    parameter int          NUM_PARAMS         = 16,
    parameter int          SYNC_COMMIT        = 1,
    parameter logic [31:0] INIT_VALUE         = 32'h0
) (
    input  logic                            s00_axi_aclk,
    input  logic                            s00_axi_areset,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
    input  logic [2:0]                      s00_axi_awprot,
    input  logic                            s00_axi_awvalid,
    output logic                            s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
    input  logic                            s00_axi_wvalid,
    output logic                            s00_axi_wready,
    output logic [1:0]                      s00_axi_bresp,
    output logic                            s00_axi_bvalid,
    input  logic                            s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
    input  logic [2:0]                      s00_axi_arprot,
    input  logic                            s00_axi_arvalid,
    output logic                            s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
    output logic [1:0]                      s00_axi_rresp,
    output logic                            s00_axi_rvalid,
    input  logic                            s00_axi_rready,
    input  logic                            step_sync,
    output logic [NUM_PARAMS*32-1:0]        params_o,
    output logic                            params_upd_o,
    output logic                            commit_pend_o
);

    localparam int IDX_W    = C_S_AXI_ADDR_WIDTH - 2;
    localparam int NUM_REGS = reg_count(NUM_PARAMS);

    if (C_S_AXI_DATA_WIDTH != 32) begin : g_bad_data_width
        $error("param_bank_axil: C_S_AXI_DATA_WIDTH must be 32");
    end
    if (NUM_PARAMS < 1 || NUM_PARAMS > 64) begin : g_bad_num_params
        $error("param_bank_axil: NUM_PARAMS must be within 1..64");
    end
    if (4 * NUM_REGS > (1 << C_S_AXI_ADDR_WIDTH)) begin : g_bad_addr_width
        $error("param_bank_axil: C_S_AXI_ADDR_WIDTH too small for NUM_PARAMS");
    end

    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    logic [31:0]      wr_data;
    logic [3:0]       wr_strb;
    logic             unused_rd_en;
    logic [IDX_W-1:0] rd_idx;
    logic [31:0]      rd_data;
    logic             rd_err;
    logic             unused_prot;

    logic [31:0] shadow [NUM_PARAMS];
    logic [31:0] active [NUM_PARAMS];
    logic        pending;
    logic [15:0] commit_count;
    logic        commit_fire;
    logic        ctrl_wr;

    assign unused_prot = ^{s00_axi_awprot, s00_axi_arprot, unused_rd_en};

    param_bank_axil_if #(
        .ADDR_WIDTH (C_S_AXI_ADDR_WIDTH),
        .NUM_REGS   (NUM_REGS)
    ) u_if (
        .clk     (s00_axi_aclk),
        .rst     (s00_axi_areset),
        .awaddr  (s00_axi_awaddr),
        .awvalid (s00_axi_awvalid),
        .awready (s00_axi_awready),
        .wdata   (s00_axi_wdata),
        .wstrb   (s00_axi_wstrb),
        .wvalid  (s00_axi_wvalid),
        .wready  (s00_axi_wready),
        .bresp   (s00_axi_bresp),
        .bvalid  (s00_axi_bvalid),
        .bready  (s00_axi_bready),
        .araddr  (s00_axi_araddr),
        .arvalid (s00_axi_arvalid),
        .arready (s00_axi_arready),
        .rdata   (s00_axi_rdata),
        .rresp   (s00_axi_rresp),
        .rvalid  (s00_axi_rvalid),
        .rready  (s00_axi_rready),
        .wr_en   (wr_en),
        .wr_idx  (wr_idx),
        .wr_data (wr_data),
        .wr_strb (wr_strb),
        .rd_en   (unused_rd_en),
        .rd_idx  (rd_idx),
        .rd_data (rd_data),
        .rd_err  (rd_err)
    );

    // pending is a register, so a COMMIT landing with step_sync waits for the next strobe.
    assign commit_fire = pending & ((SYNC_COMMIT != 0) ? step_sync : 1'b1);
    assign ctrl_wr     = wr_en && (wr_idx == IDX_W'(REG_CTRL));

    // Active copies take the pre-write shadow when a write and a transfer coincide.
    always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
        if (s00_axi_areset) begin
            for (int k = 0; k < NUM_PARAMS; k++) begin
                shadow[k] <= INIT_VALUE;
                active[k] <= INIT_VALUE;
            end
        end else begin
            for (int k = 0; k < NUM_PARAMS; k++) begin
                if (commit_fire) begin
                    active[k] <= shadow[k];
                end
                if (wr_en && (wr_idx == IDX_W'(SHADOW_BASE + k))) begin
                    for (int b = 0; b < 4; b++) begin
                        if (wr_strb[b]) begin
                            shadow[k][8*b +: 8] <= wr_data[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
        if (s00_axi_areset) begin
            pending      <= 1'b0;
            commit_count <= '0;
            params_upd_o <= 1'b0;
        end else begin
            params_upd_o <= commit_fire;
            if (commit_fire) begin
                commit_count <= commit_count + 16'd1;
            end
            if (ctrl_wr && wr_data[CTRL_ABORT_BIT]) begin
                pending <= 1'b0;
            end else if (ctrl_wr && wr_data[CTRL_COMMIT_BIT]) begin
                pending <= 1'b1;
            end else if (commit_fire) begin
                pending <= 1'b0;
            end
        end
    end

    always_comb begin
        rd_data = '0;
        rd_err  = 1'b0;
        if (32'(rd_idx) >= NUM_REGS) begin
            rd_err = 1'b1;
        end else if (rd_idx == IDX_W'(REG_STATUS)) begin
            rd_data = {commit_count, 15'd0, pending};
        end else if (rd_idx == IDX_W'(REG_NUM)) begin
            rd_data = 32'(NUM_PARAMS);
        end
        for (int k = 0; k < NUM_PARAMS; k++) begin
            if (rd_idx == IDX_W'(SHADOW_BASE + k)) begin
                rd_data = shadow[k];
            end
            if (rd_idx == IDX_W'(SHADOW_BASE + NUM_PARAMS + k)) begin
                rd_data = active[k];
            end
        end
    end

    for (genvar k = 0; k < NUM_PARAMS; k++) begin : g_params
        assign params_o[32*k +: 32] = active[k];
    end

    assign commit_pend_o = pending;

endmodule
